// File: rtl/tdc_pkg.sv
// tdc_pkg: shared channel codes, bin geometry and FSM state for the TDC histogrammer.
package tdc_pkg;
    localparam logic [1:0] CH_NONE = 2'b00;
    localparam logic [1:0] CH_P2 = 2'b01;
    localparam logic [1:0] CH_P1 = 2'b10;
    localparam logic [1:0] CH_BOTH = 2'b11;
    localparam int INTERVAL_W = 6;
    localparam logic [INTERVAL_W-1:0] INTERVAL_OVF = 6'd63;
    localparam int BIN_ADDR_W = 7;
    localparam int NUM_BINS = 128;
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ACQ} state_t;
endpackage

// File: rtl/hist_ram.sv
// hist_ram: 128-entry simple dual-port bin RAM with a registered read port.
module hist_ram
    import tdc_pkg::*;
#(
    parameter int W = 24
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [BIN_ADDR_W-1:0] waddr,
    input  logic [W-1:0]          wdata,
    input  logic [BIN_ADDR_W-1:0] raddr,
    output logic [W-1:0]          rdata
);
    logic [W-1:0] mem [NUM_BINS];
    // Write-first bypass: a readout issued in the cycle the last RMW write lands sees the new count.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end
endmodule

// File: rtl/tdc_histogrammer.sv
// tdc_histogrammer: signed-delay pulse1/pulse2 coincidence histogram over a programmable window.
module tdc_histogrammer
    import tdc_pkg::*;
#(
    parameter int COUNT_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            START_signal,
    input  logic [1:0]            END_signal,
    input  logic [INTERVAL_W-1:0] INTERVAL,
    input  logic                  data_arrived,
    input  logic                  acq_start,
    input  logic [31:0]           acq_len,
    input  logic                  clear,
    input  logic                  rd_en,
    input  logic [BIN_ADDR_W-1:0] rd_addr,
    output logic [COUNT_W-1:0]    rd_data,
    output logic                  rd_valid,
    output logic [COUNT_W-1:0]    singles1,
    output logic [COUNT_W-1:0]    singles2,
    output logic [COUNT_W-1:0]    overflow_cnt,
    output logic                  busy,
    output logic                  acq_done
);
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] x, input logic inc);
        return x + COUNT_W'(inc && !(&x));
    endfunction

    state_t state;
    logic [31:0] down_cnt;
    logic tail;
    logic [BIN_ADDR_W-1:0] clr_addr;
    logic data_arrived_q;
    logic p1, p2;
    logic [BIN_ADDR_W-1:0] a1, a2;
    logic ev, count_ev, ovf, both, pair_ok, bin_hit;
    logic [BIN_ADDR_W-1:0] bin_addr;
    logic ram_we;
    logic [BIN_ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [COUNT_W-1:0] ram_wdata, ram_q;

    // The tail cycle keeps the read port on the RMW pipeline for an event seen in the last window cycle.
    always_comb begin
        ev = data_arrived & ~data_arrived_q;
        count_ev = ev && state == S_ACQ && !tail;
        ovf = INTERVAL == INTERVAL_OVF;
        both = END_signal == CH_BOTH;
        pair_ok = (END_signal == CH_P2 && START_signal == CH_P1) ||
                  (END_signal == CH_P1 && START_signal == CH_P2);
        bin_addr = both ? '0 : {END_signal[1], INTERVAL};
        bin_hit = !ovf && (both || pair_ok) && bin_addr != BIN_ADDR_W'(NUM_BINS / 2);
        ram_raddr = state == S_ACQ ? a1 : rd_addr;
        ram_we = state == S_CLEAR || p2;
        ram_waddr = state == S_CLEAR ? clr_addr : a2;
        ram_wdata = state == S_CLEAR ? '0 : sat_inc(ram_q, 1'b1);
        rd_data = rd_valid ? ram_q : '0;
    end

    hist_ram #(.W(COUNT_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy <= 1'b0;
            acq_done <= 1'b0;
            down_cnt <= '0;
            tail <= 1'b0;
            clr_addr <= '0;
            data_arrived_q <= 1'b0;
            p1 <= 1'b0;
            p2 <= 1'b0;
            a1 <= '0;
            a2 <= '0;
            rd_valid <= 1'b0;
            singles1 <= '0;
            singles2 <= '0;
            overflow_cnt <= '0;
        end else begin
            data_arrived_q <= data_arrived;
            acq_done <= 1'b0;
            rd_valid <= rd_en && state == S_IDLE && !clear && !acq_start;
            p1 <= count_ev && bin_hit;
            a1 <= bin_addr;
            p2 <= p1;
            a2 <= a1;
            if (count_ev) begin
                singles1 <= sat_inc(singles1, END_signal[1]);
                singles2 <= sat_inc(singles2, END_signal[0]);
                overflow_cnt <= sat_inc(overflow_cnt, ovf);
            end
            case (state)
                S_IDLE: begin
                    if (clear || acq_start) begin
                        state <= clear ? S_CLEAR : S_ACQ;
                        busy <= 1'b1;
                        clr_addr <= '0;
                        tail <= 1'b0;
                        down_cnt <= acq_len;
                        singles1 <= '0;
                        singles2 <= '0;
                        overflow_cnt <= '0;
                    end
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == BIN_ADDR_W'(NUM_BINS - 1)) begin
                        state <= S_IDLE;
                        busy <= 1'b0;
                    end
                end
                S_ACQ: begin
                    if (tail) begin
                        state <= S_IDLE;
                        busy <= 1'b0;
                        acq_done <= 1'b1;
                    end else if (down_cnt == '0) begin
                        tail <= 1'b1;
                    end else begin
                        down_cnt <= down_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tdc_histogrammer.sv
// tb_tdc_histogrammer: table-driven event checks plus directed window, saturation and reset sequences.
`timescale 1ns/1ps
module tb_tdc_histogrammer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] START_signal = '0, END_signal = '0;
    logic [5:0] INTERVAL = '0;
    logic data_arrived = 1'b0, acq_start = 1'b0, clear = 1'b0, rd_en = 1'b0;
    logic [31:0] acq_len = '0;
    logic [6:0] rd_addr = '0;
    logic [23:0] rd_data, singles1, singles2, overflow_cnt;
    logic rd_valid, busy, acq_done;
    logic [3:0] rd_data4, singles1_4, singles2_4, overflow_cnt4;
    logic rd_valid4, busy4, acq_done4;
    int n_chk = 0, n_fail = 0, done_cnt = 0;

    always #1 clk = ~clk;

    tdc_histogrammer #(.COUNT_W(24)) dut (
        .clk(clk), .rst(rst), .START_signal(START_signal), .END_signal(END_signal),
        .INTERVAL(INTERVAL), .data_arrived(data_arrived), .acq_start(acq_start), .acq_len(acq_len),
        .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .singles1(singles1), .singles2(singles2), .overflow_cnt(overflow_cnt), .busy(busy),
        .acq_done(acq_done)
    );

    tdc_histogrammer #(.COUNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .START_signal(START_signal), .END_signal(END_signal),
        .INTERVAL(INTERVAL), .data_arrived(data_arrived), .acq_start(acq_start), .acq_len(acq_len),
        .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data4), .rd_valid(rd_valid4),
        .singles1(singles1_4), .singles2(singles2_4), .overflow_cnt(overflow_cnt4), .busy(busy4),
        .acq_done(acq_done4)
    );

    always @(posedge clk) if (acq_done) done_cnt++;

    typedef struct {
        logic [1:0] st;
        logic [1:0] en;
        logic [5:0] iv;
        logic [6:0] addr;
        int bin;
        int s1;
        int s2;
        int ovf;
    } vec_t;
    vec_t tbl[9];
    int exp_mem[128];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic rd(input logic [6:0] a, output logic [31:0] v, output logic [31:0] v4);
        rd_en = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        chk($sformatf("rd_valid[%0d]", a), {31'b0, rd_valid}, 1);
        v = {8'b0, rd_data};
        v4 = {28'b0, rd_data4};
    endtask

    task automatic fire_ev(input logic [1:0] st, input logic [1:0] en, input logic [5:0] iv);
        START_signal = st;
        END_signal = en;
        INTERVAL = iv;
        data_arrived = 1'b1;
        repeat (3) @(negedge clk);
        data_arrived = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic start_acq(input logic [31:0] len);
        acq_len = len;
        acq_start = 1'b1;
        @(negedge clk);
        acq_start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("acq_done_seen", {31'b0, done_cnt != d0}, 1);
        repeat (4) @(negedge clk);
        chk("acq_done_once", done_cnt - d0, 1);
    endtask

    initial begin
        logic [31:0] v, v4;
        int cyc, d0;
        tbl[0] = '{2'b10, 2'b01, 6'd5, 7'd5, 1, 0, 1, 0};
        tbl[1] = '{2'b01, 2'b10, 6'd12, 7'd76, 1, 1, 0, 0};
        tbl[2] = '{2'b01, 2'b10, 6'd12, 7'd76, 2, 1, 0, 0};
        tbl[3] = '{2'b01, 2'b10, 6'd12, 7'd76, 3, 1, 0, 0};
        tbl[4] = '{2'b00, 2'b11, 6'd7, 7'd0, 1, 1, 1, 0};
        tbl[5] = '{2'b10, 2'b01, 6'd63, 7'd63, 0, 0, 1, 1};
        tbl[6] = '{2'b11, 2'b01, 6'd9, 7'd9, 0, 0, 1, 0};
        tbl[7] = '{2'b01, 2'b10, 6'd0, 7'd64, 0, 1, 0, 0};
        tbl[8] = '{2'b10, 2'b10, 6'd5, 7'd5, 1, 1, 0, 0};
        for (int i = 0; i < 128; i++) exp_mem[i] = 0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_acq_done", {31'b0, acq_done}, 0);
        chk("reset_rd_valid", {31'b0, rd_valid}, 0);
        chk("reset_rd_data", {8'b0, rd_data}, 0);
        chk("reset_singles1", {8'b0, singles1}, 0);
        chk("reset_singles2", {8'b0, singles2}, 0);
        chk("reset_overflow", {8'b0, overflow_cnt}, 0);

        clear = 1'b1;
        acq_start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        acq_start = 1'b0;
        cyc = 0;
        while (busy && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("clear_busy_cycles", cyc, 128);
        chk("clear_no_acq_done", done_cnt, 0);
        for (int a = 0; a < 128; a++) begin
            rd(7'(a), v, v4);
            chk($sformatf("cleared_bin[%0d]", a), v, 0);
            chk($sformatf("cleared_bin4[%0d]", a), v4, 0);
        end

        for (int i = 0; i < 9; i++) begin
            d0 = done_cnt;
            start_acq(1000);
            fire_ev(tbl[i].st, tbl[i].en, tbl[i].iv);
            wait_done(d0);
            exp_mem[tbl[i].addr] = tbl[i].bin;
            rd(tbl[i].addr, v, v4);
            chk($sformatf("vec%0d_bin[%0d]", i, tbl[i].addr), v, tbl[i].bin);
            chk($sformatf("vec%0d_singles1", i), {8'b0, singles1}, tbl[i].s1);
            chk($sformatf("vec%0d_singles2", i), {8'b0, singles2}, tbl[i].s2);
            chk($sformatf("vec%0d_overflow", i), {8'b0, overflow_cnt}, tbl[i].ovf);
        end
        for (int a = 0; a < 128; a++) begin
            rd(7'(a), v, v4);
            chk($sformatf("hist_bin[%0d]", a), v, exp_mem[a]);
            chk($sformatf("hist_bin4[%0d]", a), v4, exp_mem[a]);
        end

        // Saturation: 17 hits in bin 3 wrap-free in the 24-bit instance, pinned at 15 in the 4-bit one.
        d0 = done_cnt;
        start_acq(1000);
        for (int k = 0; k < 17; k++) fire_ev(2'b10, 2'b01, 6'd3);
        wait_done(d0);
        rd(7'd3, v, v4);
        chk("sat_bin3_w24", v, 17);
        chk("sat_bin3_w4", v4, 15);
        chk("sat_singles2_w24", {8'b0, singles2}, 17);
        chk("sat_singles2_w4", {28'b0, singles2_4}, 15);

        // Single-cycle window with the rising edge landing in that only ACQ cycle.
        d0 = done_cnt;
        acq_len = 0;
        acq_start = 1'b1;
        @(negedge clk);
        acq_start = 1'b0;
        START_signal = 2'b10;
        END_signal = 2'b01;
        INTERVAL = 6'd20;
        data_arrived = 1'b1;
        repeat (3) @(negedge clk);
        data_arrived = 1'b0;
        repeat (10) @(negedge clk);
        chk("last_cycle_done_once", done_cnt - d0, 1);
        chk("last_cycle_singles2", {8'b0, singles2}, 1);
        rd(7'd20, v, v4);
        chk("last_cycle_bin20", v, 1);

        // A second acq_start mid-window must not restart or extend the window.
        d0 = done_cnt;
        start_acq(100);
        cyc = 0;
        while (!acq_done && cyc < 400) begin
            acq_start = cyc == 20;
            if (cyc == 20) acq_len = 5000;
            if (cyc == 50) chk("ignore_busy_mid", {31'b0, busy}, 1);
            @(negedge clk);
            cyc++;
        end
        acq_start = 1'b0;
        chk("ignore_done_cycle", cyc, 102);
        repeat (200) @(negedge clk);
        chk("ignore_busy_after", {31'b0, busy}, 0);
        chk("ignore_done_once", done_cnt - d0, 1);

        // Reset mid-window aborts quietly.
        start_acq(1000);
        fire_ev(2'b01, 2'b10, 6'd30);
        repeat (44) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        chk("rst_abort_busy", {31'b0, busy}, 0);
        chk("rst_abort_singles1", {8'b0, singles1}, 0);
        repeat (1100) @(negedge clk);
        chk("rst_abort_no_done", done_cnt - d0, 0);
        chk("rst_abort_busy_late", {31'b0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tdc_histogrammer.md
# tdc_histogrammer

Consumes the event stream of the two-channel TDC (`START_signal`, `END_signal`, `INTERVAL`, `data_arrived`) and accumulates a signed-delay coincidence histogram of pulse1/pulse2 over a programmable acquisition window. It sits directly downstream of the TDC, in the same 500 MHz `clk` domain. It exposes a 128-bin readout port and per-channel singles and overflow counters to the host-side readout logic.

## Interface
- `COUNT_W`, 24, width of every bin and counter; all counters saturate at all-ones.
- `clk`  in  1  500 MHz system clock (2 ns/cycle); same clock as the TDC.
- `rst`  in  1  synchronous, active-high reset.
- `START_signal`  in  2  TDC previous-event channel code, `{pulse1,pulse2}`.
- `END_signal`  in  2  TDC current-event channel code, `{pulse1,pulse2}`.
- `INTERVAL`  in  6  TDC delay in clk cycles; 63 means out of range.
- `data_arrived`  in  1  TDC event flag; high for at least 3 cycles per event.
- `acq_start`  in  1  one-cycle request to start acquisition.
- `acq_len`  in  32  acquisition window in clk cycles; sampled on accepted `acq_start`.
- `clear`  in  1  one-cycle request to zero all bins and counters.
- `rd_en`  in  1  bin read request.
- `rd_addr`  in  7  bin address `{dir, interval}`.
- `rd_data`  out  COUNT_W  bin contents.
- `rd_valid`  out  1  `rd_data` is valid.
- `singles1`, `singles2`, `overflow_cnt`  out  COUNT_W each  event counters.
- `busy`  out  1  high in CLEAR or ACQ.
- `acq_done`  out  1  one-cycle pulse at the end of the window.

## Operation
- FSM states are IDLE, CLEAR, ACQ.
  - IDLE→CLEAR on `clear`. CLEAR sweeps addresses 0..127 writing 0, one per cycle, for 128 cycles, zeroes the three counters, then returns to IDLE.
  - IDLE→ACQ on `acq_start`. It loads the down-counter with `acq_len` and also zeroes the three counters; bins are not zeroed.
  - `clear` and `acq_start` in the same cycle: `clear` wins.
  - Both requests are ignored outside IDLE.
  - ACQ→IDLE when the down-counter reaches 0. `acq_done` pulses in the cycle the state returns to IDLE.
  - `acq_len`=0 gives a single ACQ cycle, then done.
- Event detect: `ev = data_arrived & ~data_arrived_q`. The fields are sampled in the `ev` cycle. Only events sampled while the state is ACQ count, including the last ACQ cycle.
- Classification (END[1]=pulse1, END[0]=pulse2):
  - `INTERVAL`==63: `overflow_cnt`+1, no bin update, START ignored.
  - END=11: bin 0 +1 (zero-delay coincidence); `singles1`+1 and `singles2`+1.
  - END=01 with START=10: bin `{0,INTERVAL}` +1 (pulse1 leads pulse2).
  - END=10 with START=01: bin `{1,INTERVAL}` +1 (pulse2 leads pulse1).
  - Any other START/END pair: no bin update.
  - For END ≠ 11, `singles1`+=END[1] and `singles2`+=END[0]; this applies to every event, including the 63 case.
- Bin 64 is never written by acquisition.
- Bin updates are read-modify-write with saturation at 2^COUNT_W−1.
- Events closer than the TDC's `data_arrived` low time merge into one rising edge; the later event is lost. This is a documented limitation, not an error.
- Readout is honoured in IDLE only. In CLEAR/ACQ, `rd_valid` stays 0 and `rd_data` holds 0.

## Timing
- Reset: state IDLE; `busy`, `acq_done`, `rd_valid`=0; `rd_data`, all counters, `data_arrived_q`, down-counter=0.
- Bin RAM contents are undefined after reset; a `clear` is required before the first acquisition.
- `rst` mid-CLEAR or mid-ACQ aborts to IDLE with no `acq_done`.
- Event pipeline:
  - cycle N (`ev`): classify and register the address.
  - N+1: RAM read.
  - N+2: write of the incremented value.
  - Counters update at N+1.
- Rising edges are ≥4 cycles apart, so no RMW hazard forwarding is needed.
- An event sampled in the last ACQ cycle still completes its write by N+2. `acq_done` is delayed to N+2 so that all writes land before IDLE readout.
- Read: `rd_en` at cycle R → `rd_data`/`rd_valid` at R+1; `rd_valid` is high for one cycle per request.
- `busy` rises the cycle after an accepted request and falls with the return to IDLE.

## Structure
- Package `tdc_pkg` holds:
  - `CH_NONE`=2'b00, `CH_P2`=2'b01, `CH_P1`=2'b10, `CH_BOTH`=2'b11;
  - `INTERVAL_W`=6, `INTERVAL_OVF`=6'd63, `BIN_ADDR_W`=7, `NUM_BINS`=128;
  - the FSM state enum.
- Sub-module `hist_ram`: 128×COUNT_W simple dual-port RAM, one write port and one read port, registered 1-cycle read. The read port is muxed between the RMW pipeline (ACQ) and the readout path (IDLE).

## Test plan
- Reset, `clear`, then read all 128 bins: `busy` is high for exactly 128 cycles, then every `rd_data`=0.
- With `acq_len`=1000, one event END=01, START=10, INTERVAL=5 → bin 5=1, `singles2`=1, `singles1`=0, `acq_done` pulses once.
- END=10, START=01, INTERVAL=12, repeated 3 times → bin 76 (`{1,12}`)=3; END=11 event → bin 0=1, `singles1`=`singles2`=1.
- INTERVAL=63 event with END=01 → `overflow_cnt`=1, `singles2`=1, no bin changed; START=11, END=01 event → no bin changed.
- Preload via `COUNT_W`=4: 17 events into bin 3 → bin 3=15 (saturated).
- Event whose rising edge falls in the last ACQ cycle is counted. `acq_start` during ACQ is ignored. `rst` mid-ACQ gives IDLE with no `acq_done`.
